// File: rtl/cout_mon_if.sv
// cout_mon_if: bundle between the carry-out monitor and whoever drives and reads it.
//   master: drives en, cout_in, cnt_in, thr, clr, ack; reads evt_cnt, irq, snap, ovf, state
//   slave : the monitor side (mirror of master)
interface cout_mon_if #(parameter int W = 8);
    logic         en;
    logic         cout_in;
    logic [3:0]   cnt_in;
    logic [W-1:0] thr;
    logic         clr;
    logic         ack;
    logic [W-1:0] evt_cnt;
    logic         irq;
    logic [3:0]   snap;
    logic         ovf;
    logic [1:0]   state;
    modport master (output en, cout_in, cnt_in, thr, clr, ack,
                    input  evt_cnt, irq, snap, ovf, state);
    modport slave  (input  en, cout_in, cnt_in, thr, clr, ack,
                    output evt_cnt, irq, snap, ovf, state);
endinterface

// File: rtl/cout_event_monitor.sv
// cout_event_monitor: counts rising edges of an upstream carry-out and raises a held threshold interrupt.
//   clk, rst : clock and synchronous active-high reset
//   bus      : cout_mon_if.slave -- en, cout_in, cnt_in, thr, clr, ack in;
//              evt_cnt, irq, snap, ovf, state out (all registered)
//   COUT_MON_SAT_EN : when defined evt_cnt saturates at all-ones instead of wrapping
module cout_event_monitor #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst,
    cout_mon_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ALERT = 2'd2} st_t;
    st_t          st, st_n;
    logic         cout_d;
    logic [W-1:0] evt_cnt, cnt_n;
    logic [3:0]   snap, snap_n;
    logic         ovf, ovf_n;
    logic         ev, full, count, hit;
    assign ev    = bus.cout_in & ~cout_d;
    assign full  = &evt_cnt;
    assign count = bus.en & ev & (st == RUN || st == ALERT);
    // a full counter can never step onto a non-zero threshold, so at most one alert per clr when saturating
    assign hit   = (st == RUN) & bus.en & ev & (|bus.thr) & ~full & (evt_cnt + W'(1) == bus.thr);
    always_comb begin
        st_n   = st;
        cnt_n  = evt_cnt;
        snap_n = snap;
        ovf_n  = ovf;
        if (bus.clr) begin
            st_n   = bus.en ? RUN : IDLE;
            cnt_n  = '0;
            snap_n = '0;
            ovf_n  = 1'b0;
        end else begin
            if (count) begin
`ifdef COUT_MON_SAT_EN
                cnt_n = full ? evt_cnt : evt_cnt + W'(1);
`else
                cnt_n = evt_cnt + W'(1);
`endif
                ovf_n = ovf | full;
            end
            if (hit)
                snap_n = bus.cnt_in;
            case (st)
                IDLE:    st_n = bus.en ? RUN : IDLE;
                RUN:     st_n = !bus.en ? IDLE : hit ? ALERT : RUN;
                ALERT:   st_n = !bus.ack ? ALERT : bus.en ? RUN : IDLE;
                default: st_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            cout_d  <= 1'b0;
            evt_cnt <= '0;
            snap    <= '0;
            ovf     <= 1'b0;
        end else begin
            st      <= st_n;
            cout_d  <= bus.cout_in;
            evt_cnt <= cnt_n;
            snap    <= snap_n;
            ovf     <= ovf_n;
        end
    end
    assign bus.evt_cnt = evt_cnt;
    assign bus.irq     = (st == ALERT);
    assign bus.snap    = snap;
    assign bus.ovf     = ovf;
    assign bus.state   = st;
endmodule

// File: doc/cout_event_monitor.md
Name: cout_event_monitor

Overview:
Downstream consumer of the 4-bit counter's carry-out (cout) and count (cnt). It counts carry-out events, i.e. completed 16-count rollovers, in a wider counter. It raises a held interrupt when a programmable threshold is reached and keeps it high until acknowledged. It also captures a snapshot of the 4-bit count at the moment of the alert.

Parameters:
W, 8, width of the event counter and the threshold.

Ports:
clk      input   1   system clock; all logic on posedge.
rst      input   1   synchronous reset, active-high.
en       input   1   monitor enable; events are counted only while en=1.
cout_in  input   1   carry-out from the 4-bit counter; may be held high for more than one cycle.
cnt_in   input   4   current 4-bit count from the upstream counter.
thr      input   W   alert threshold; 0 disables alerts.
clr      input   1   synchronous clear of the counter, flags and snapshot.
ack      input   1   interrupt acknowledge.
evt_cnt  output  W   number of cout rising edges counted.
irq      output  1   alert; held high until acknowledged.
snap     output  4   cnt_in value captured when irq asserts.
ovf      output  1   sticky overflow flag for evt_cnt.
state    output  2   FSM state: 0=IDLE, 1=RUN, 2=ALERT.

Behaviour:
- Reset (rst=1 at posedge):
  - evt_cnt=0, irq=0, snap=0, ovf=0, state=IDLE.
  - Edge register cout_d=0.
  - rst overrides every other input.
- Edge detect:
  - cout_d <= cout_in every cycle, regardless of en or state.
  - Event ev = cout_in & ~cout_d.
  - A level held N cycles counts once.
- Priority, highest first: rst, clr, ack, ev.
- clr:
  - evt_cnt=0, irq=0, snap=0, ovf=0.
  - Next state = RUN if en=1, otherwise IDLE.
  - An ev in the same cycle is dropped.
- IDLE:
  - Events are ignored; outputs hold.
  - en=1 moves to RUN at the next posedge.
  - An event on that same edge is not counted.
- RUN:
  - en=0 moves to IDLE; an event in that cycle is ignored; evt_cnt is held, not cleared.
  - en=1 and ev: evt_cnt <= evt_cnt+1, visible one cycle after the sampled rising edge.
  - If thr!=0 and evt_cnt+1 == thr:
    - Go to ALERT; irq=1 and snap<=cnt_in on the same edge as the increment.
- ALERT:
  - irq stays high.
  - Events are still counted while en=1, but no second alert is raised.
  - en=0 does not leave ALERT; counting stops.
  - ack=1: irq=0 at the next edge.
    - Next state = RUN if en=1, otherwise IDLE.
    - An ev in the ack cycle is still counted.
  - ack outside ALERT is ignored.
- Threshold compare:
  - Compared against the live thr value.
  - If evt_cnt is already past thr, there is no alert until a wrap brings it back to equality.
  - thr changes never generate an alert without an event.
- Wrap (macro not defined):
  - All-ones + 1 -> 0 and sets ovf (sticky until rst or clr).
  - The threshold is re-armable after the wrap.
- Latency: one cycle from the sampled cout_in rise to the evt_cnt and irq update. There is no combinational path from inputs to outputs.

Optional Feature:
COUT_MON_SAT_EN:
- Defined: evt_cnt saturates at all-ones.
  - An event arriving at all-ones leaves evt_cnt unchanged and sets ovf.
  - Because the count can never return to thr, at most one alert fires per clr.
- Not defined: wrap behaviour as described under Behaviour (roll to 0, set ovf, threshold re-armable).

Test Plan:
1. Reset and hold:
   - Stimulus: rst=1 for 2 cycles, en=0, cout_in toggling.
   - Response: evt_cnt=0, irq=0, snap=0, ovf=0, state=0 throughout.
2. Edge counting:
   - Stimulus: en=1, thr=0; cout_in high 3 cycles, low 2, high 1.
   - Response: evt_cnt=2, irq stays 0.
3. Threshold alert:
   - Stimulus: thr=3, cnt_in=4'd0 on the 3rd cout rise.
   - Response: one cycle later evt_cnt=3, irq=1, snap=0, state=2.
   - Stimulus: 2 more events.
   - Response: evt_cnt=5, irq still 1.
   - Stimulus: ack pulse.
   - Response: irq=0, state=1.
4. Enable gating:
   - Stimulus: en dropped in RUN with evt_cnt=5, then 4 cout rises, then en=1.
   - Response: evt_cnt stays 5, state=0 then 1.
5. Clear priority:
   - Stimulus: clr and an ev in the same cycle while irq=1, evt_cnt=9.
   - Response: next cycle evt_cnt=0, irq=0, ovf=0, state=1.
6. Wrap and saturation, W=8, thr=0:
   - Stimulus: 256 events.
   - Response without macro: evt_cnt=0, ovf=1.
   - Response with COUT_MON_SAT_EN: evt_cnt=8'hFF, ovf=1.
